// File: rtl/mul_acc_pipe.sv
// Pipelined multiply / multiply-accumulate unit with a run-controlled sample window.
// Datapath: input reg -> MUL_STAGES product regs -> acc; out0 is a shifted view of acc.
module mul_acc_pipe #(
    parameter int DATA_W     = 32,
    parameter int MUL_STAGES = 1,
    parameter int ACC_W      = 2*DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [1:0]        cfg_mode,
    input  logic              cfg_signed,
    input  logic [5:0]        cfg_shift,
    input  logic [15:0]       cfg_delay,
    input  logic [15:0]       cfg_len,
    output logic [DATA_W-1:0] out0,
    output logic              running,
    output logic              done
);

    localparam int PW = 2*DATA_W;

    typedef enum logic [1:0] {IDLE, DELAY, ACTIVE, DRAIN} state_t;

    state_t                      state;
    logic [15:0]                 dly_cnt, len_cnt, len_q;
    logic [1:0]                  mode_q;
    logic                        sgn_q;
    logic [5:0]                  shift_q;
    logic                        out_sgn;
    logic [5:0]                  out_shift;
    logic [DATA_W-1:0]           a_q, b_q;
    logic [MUL_STAGES:0]         vld_pipe, first_pipe, last_pipe;
    logic [MUL_STAGES:1][PW-1:0] prod_pipe;
    logic [ACC_W-1:0]            acc;

    logic [PW-1:0]    a_ext, b_ext, prod_nxt;
    logic [ACC_W-1:0] prod_ext, acc_base, acc_sh;
    logic             sample, tail_last;

    assign sample    = (state == ACTIVE);
    assign tail_last = vld_pipe[MUL_STAGES] & last_pipe[MUL_STAGES];

    // Control FSM; done/running are registered so done lines up with the final acc write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            dly_cnt <= '0;
            len_cnt <= '0;
            len_q   <= '0;
            mode_q  <= '0;
            sgn_q   <= 1'b0;
            shift_q <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (done)
                running <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        mode_q  <= cfg_mode;
                        sgn_q   <= cfg_signed;
                        shift_q <= cfg_shift;
                        len_q   <= cfg_len;
                        len_cnt <= cfg_len;
                        dly_cnt <= cfg_delay;
                        running <= 1'b1;
                        if (cfg_len == 16'd0)
                            done <= 1'b1;
                        else if (cfg_delay == 16'd0)
                            state <= ACTIVE;
                        else
                            state <= DELAY;
                    end
                end
                DELAY: begin
                    dly_cnt <= dly_cnt - 16'd1;
                    if (dly_cnt == 16'd1)
                        state <= ACTIVE;
                end
                ACTIVE: begin
                    len_cnt <= len_cnt - 16'd1;
                    if (len_cnt == 16'd1)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (tail_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operands extended to full product width so one unsigned multiply serves both signednesses.
    assign a_ext    = {{DATA_W{sgn_q & a_q[DATA_W-1]}}, a_q};
    assign b_ext    = {{DATA_W{sgn_q & b_q[DATA_W-1]}}, b_q};
    assign prod_nxt = a_ext * b_ext;

    always_comb begin
        prod_ext = ACC_W'(prod_pipe[MUL_STAGES]);
        if (sgn_q)
            prod_ext = ACC_W'($signed(prod_pipe[MUL_STAGES]));
        acc_base = first_pipe[MUL_STAGES] ? '0 : acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            vld_pipe   <= '0;
            first_pipe <= '0;
            last_pipe  <= '0;
            prod_pipe  <= '0;
        end else begin
            if (sample) begin
                a_q <= in0;
                b_q <= in1;
            end
            vld_pipe[0]   <= sample;
            first_pipe[0] <= sample & (len_cnt == len_q);
            last_pipe[0]  <= sample & (len_cnt == 16'd1);
            prod_pipe[1]  <= prod_nxt;
            for (int i = 1; i <= MUL_STAGES; i++) begin
                vld_pipe[i]   <= vld_pipe[i-1];
                first_pipe[i] <= first_pipe[i-1];
                last_pipe[i]  <= last_pipe[i-1];
            end
            for (int i = 2; i <= MUL_STAGES; i++)
                prod_pipe[i] <= prod_pipe[i-1];
        end
    end

    // Output shift config follows the first result of a run so out0 holds across idle time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            out_sgn   <= 1'b0;
            out_shift <= '0;
        end else if (vld_pipe[MUL_STAGES]) begin
            case (mode_q)
                2'b01:   acc <= acc_base + prod_ext;
                2'b10:   acc <= acc_base - prod_ext;
                default: acc <= prod_ext;
            endcase
            if (first_pipe[MUL_STAGES]) begin
                out_sgn   <= sgn_q;
                out_shift <= shift_q;
            end
        end
    end

    always_comb begin
        if (32'(out_shift) >= ACC_W)
            acc_sh = out_sgn ? {ACC_W{acc[ACC_W-1]}} : '0;
        else if (out_sgn)
            acc_sh = $signed(acc) >>> out_shift;
        else
            acc_sh = acc >> out_shift;
    end

    assign out0 = acc_sh[DATA_W-1:0];

endmodule

// File: tb/tb_mul_acc_pipe.sv
// Directed bench for mul_acc_pipe: two instances (1 and 4 product stages) on shared stimulus,
// expected results queued at run time and popped at each done.
module tb_mul_acc_pipe;

    logic        clk = 1'b0;
    logic        rst, run;
    logic [31:0] in0, in1;
    logic [1:0]  cfg_mode;
    logic        cfg_signed;
    logic [5:0]  cfg_shift;
    logic [15:0] cfg_delay, cfg_len;
    logic [31:0] out0_a, out0_b;
    logic        running_a, running_b, done_a, done_b;

    int total = 0;
    int bad   = 0;

    logic [31:0] va[16];
    logic [31:0] vb[16];
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic [31:0] last_exp;

    always #5 clk = ~clk;

    mul_acc_pipe #(.DATA_W(32), .MUL_STAGES(1)) u_a (
        .clk(clk), .rst(rst), .run(run), .in0(in0), .in1(in1),
        .cfg_mode(cfg_mode), .cfg_signed(cfg_signed), .cfg_shift(cfg_shift),
        .cfg_delay(cfg_delay), .cfg_len(cfg_len),
        .out0(out0_a), .running(running_a), .done(done_a)
    );

    mul_acc_pipe #(.DATA_W(32), .MUL_STAGES(4)) u_b (
        .clk(clk), .rst(rst), .run(run), .in0(in0), .in1(in1),
        .cfg_mode(cfg_mode), .cfg_signed(cfg_signed), .cfg_shift(cfg_shift),
        .cfg_delay(cfg_delay), .cfg_len(cfg_len),
        .out0(out0_b), .running(running_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pair(input int k, input int a, input int b);
        va[k] = 32'(a);
        vb[k] = 32'(b);
    endtask

    function automatic logic [31:0] model(input int mode, input bit sg, input int sh, input int len);
        logic [63:0]        acc, p, r;
        logic signed [63:0] sa, sb;
        acc = '0;
        for (int k = 0; k < len; k++) begin
            if (sg) begin
                sa = $signed(va[k]);
                sb = $signed(vb[k]);
                p  = sa * sb;
            end else begin
                p = {32'd0, va[k]} * {32'd0, vb[k]};
            end
            case (mode)
                1:       acc = ((k == 0) ? 64'd0 : acc) + p;
                2:       acc = ((k == 0) ? 64'd0 : acc) - p;
                default: acc = p;
            endcase
        end
        if (sg) r = $signed(acc) >>> sh;
        else    r = acc >> sh;
        return r[31:0];
    endfunction

    // One run: accept edge, then walk edge by edge, feeding samples and junk/ignored run pulses.
    task automatic do_run(input int dly, input int len, input int mode, input bit sg, input int sh);
        logic [31:0] e;
        int d_a, d_b, n_a, n_b, idx;
        e = (len == 0) ? last_exp : model(mode, sg, sh, len);
        last_exp = e;
        q_a.push_back(e);
        q_b.push_back(e);
        @(negedge clk);
        run        = 1'b1;
        cfg_mode   = 2'(mode);
        cfg_signed = sg;
        cfg_shift  = 6'(sh);
        cfg_delay  = 16'(dly);
        cfg_len    = 16'(len);
        @(posedge clk);
        d_a = -1; d_b = -1; n_a = 0; n_b = 0;
        for (int t = 0; t < dly + len + 20; t++) begin
            @(negedge clk);
            if (t == 0) chk("running_start", 64'(running_a), 64'd1);
            if (done_a) begin
                n_a++;
                if (d_a < 0) begin
                    d_a = t;
                    if (q_a.size() > 0) chk("out0_at_done_ms1", 64'(out0_a), 64'(q_a.pop_front()));
                end
            end
            if (done_b) begin
                n_b++;
                if (d_b < 0) begin
                    d_b = t;
                    if (q_b.size() > 0) chk("out0_at_done_ms4", 64'(out0_b), 64'(q_b.pop_front()));
                end
            end
            if (d_a >= 0 && t == d_a + 1) chk("running_off_ms1", 64'(running_a), 64'd0);
            idx = t - dly;
            if (len > 0 && idx >= 0 && idx < len) begin
                in0 = va[idx];
                in1 = vb[idx];
            end else begin
                in0 = $urandom;
                in1 = $urandom;
            end
            run        = (len > 0 && t + 1 <= dly + len) ? 1'($urandom_range(0, 1)) : 1'b0;
            cfg_mode   = 2'($urandom);
            cfg_signed = 1'($urandom);
            cfg_shift  = 6'($urandom);
            cfg_delay  = 16'($urandom_range(0, 3));
            cfg_len    = 16'($urandom_range(0, 3));
        end
        chk("done_time_ms1", 64'(d_a), (len == 0) ? 64'd0 : 64'(dly + len + 2));
        chk("done_time_ms4", 64'(d_b), (len == 0) ? 64'd0 : 64'(dly + len + 5));
        chk("done_count_ms1", 64'(n_a), 64'd1);
        chk("done_count_ms4", 64'(n_b), 64'd1);
        chk("out0_hold", 64'(out0_a), 64'(e));
    endtask

    initial begin
        int nd;
        rst = 1'b1; run = 1'b0; in0 = '0; in1 = '0;
        cfg_mode = '0; cfg_signed = 1'b0; cfg_shift = '0; cfg_delay = '0; cfg_len = '0;
        last_exp = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out0", 64'(out0_a), 64'd0);
        chk("reset_running", 64'(running_a), 64'd0);
        chk("reset_done", 64'(done_a), 64'd0);

        // Reset in the middle of an ACTIVE window.
        run = 1'b1; cfg_mode = 2'b00; cfg_len = 16'd10; cfg_delay = 16'd0;
        in0 = 32'd5; in1 = 32'd3;
        @(posedge clk);
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            run = 1'b0;
            if (t == 3) chk("pre_reset_out0", 64'(out0_a), 64'd15);
        end
        rst = 1'b1;
        #1;
        chk("midrun_rst_out0", 64'(out0_a), 64'd0);
        chk("midrun_rst_running", 64'({running_a, running_b}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int t = 0; t < 15; t++) begin
            @(negedge clk);
            if (done_a || done_b) nd++;
        end
        chk("no_done_after_rst", 64'(nd), 64'd0);
        last_exp = '0;

        set_pair(0, 7, 6);
        do_run(0, 1, 0, 1'b0, 0);          // 42

        set_pair(0, 3, -2); set_pair(1, 5, 5); set_pair(2, -4, -4); set_pair(3, 1, 0);
        do_run(0, 4, 1, 1'b1, 0);          // 35
        do_run(0, 4, 1, 1'b1, 0);          // 35 again: first sample clears acc

        set_pair(0, 2, 3); set_pair(1, 4, 1);
        do_run(0, 2, 2, 1'b1, 0);          // 0xFFFFFFF6
        do_run(0, 2, 2, 1'b1, 1);          // 0xFFFFFFFB

        set_pair(0, -1, -1);
        do_run(0, 1, 0, 1'b0, 32);         // 0xFFFFFFFE

        set_pair(0, 10, 11); set_pair(1, 2, 9); set_pair(2, -3, 7);
        do_run(5, 3, 1, 1'b1, 0);          // delay window with ignored run pulses

        do_run(2, 0, 1, 1'b0, 0);          // zero length: out0 unchanged

        set_pair(0, 100, 3); set_pair(1, 12, 12);
        do_run(1, 2, 3, 1'b0, 0);          // mode 11 behaves as MUL: 144

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 6; k++) begin
                va[k] = $urandom;
                vb[k] = $urandom;
            end
            do_run(r, 6, 1 + (r % 2), 1'(r), 3 * r + 5);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
